// File: rtl/blk_332794_if.sv
// ---------------------------------------------------------------------------
// blk_332794_if
// Command/response bundle between a clk-domain requester and the virtual-JTAG
// debug driver (blk_332794).
//
// Signals
//   cmd_valid  requester -> driver  command request
//   cmd_ready  driver -> requester  high only while the driver is idle
//   cmd_ir     requester -> driver  IR value to load (2 bits)
//   cmd_dr     requester -> driver  DR value to shift in, LSB first
//   rsp_valid  driver -> requester  one-clk pulse, response available
//   rsp_dr     driver -> requester  DR bits captured from tdo
//   rsp_ir_out driver -> requester  slave IR status sampled during update-IR
//   busy       driver -> requester  inverse of cmd_ready
//
// Modports
//   master  the requester side
//   slave   the driver side
// ---------------------------------------------------------------------------
interface blk_332794_if #(
  parameter int DR_W = 38
) ();

  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_ir;
  logic [DR_W-1:0] cmd_dr;
  logic            rsp_valid;
  logic [DR_W-1:0] rsp_dr;
  logic [1:0]      rsp_ir_out;
  logic            busy;

  modport master (
    output cmd_valid, cmd_ir, cmd_dr,
    input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out, busy
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_dr,
    output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out, busy
  );

endinterface

// File: rtl/blk_332794.sv
// ---------------------------------------------------------------------------
// blk_332794
// On-chip initiator for the Nios II debug slave's virtual-JTAG port. Each
// accepted (IR, DR) command is turned into the sequence
//   UIR -> CDR -> SDR x DR_W -> UDR -> RTI x RTI_CYC
// on a divided tck. The DR bits captured from tdo are returned on the response
// side of the bus together with the slave's IR status sampled during UIR.
//
// Parameters
//   DR_W     DR shift length in bits
//   TCK_DIV  tck half-period in clk cycles (>= 1)
//   RTI_CYC  tck periods spent in RTI after UDR (>= 1)
//
// Ports
//   clk           system clock, everything on posedge
//   reset_n       synchronous active-low reset
//   bus           blk_332794_if.slave command/response bundle
//   i_vji_tdo     serial data from the debug slave
//   i_vji_ir_out  IR status from the debug slave
//   o_vji_tck     generated tck
//   o_vji_tdi     serial data to the debug slave
//   o_vji_ir_in   IR value presented to the debug slave
//   o_vji_uir     update-IR qualifier
//   o_vji_cdr     capture-DR qualifier
//   o_vji_sdr     shift-DR qualifier
//   o_vji_udr     update-DR qualifier
//   o_vji_rti     run-test-idle qualifier
//
// Build option
//   DNN_VJTAG_DRV_IR_SKIP_EN  when defined, a command whose IR equals the IR
//   already loaded (and at least one UIR has completed since reset) skips the
//   UIR period and goes straight to CDR; the response then carries the last
//   sampled IR status. When undefined every command passes through UIR.
// ---------------------------------------------------------------------------
module blk_332794 #(
  parameter int DR_W    = 38,
  parameter int TCK_DIV = 2,
  parameter int RTI_CYC = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  blk_332794_if.slave bus,
  input  logic       i_vji_tdo,
  input  logic [1:0] i_vji_ir_out,
  output logic       o_vji_tck,
  output logic       o_vji_tdi,
  output logic [1:0] o_vji_ir_in,
  output logic       o_vji_uir,
  output logic       o_vji_cdr,
  output logic       o_vji_sdr,
  output logic       o_vji_udr,
  output logic       o_vji_rti
);

  // A divider of a single clk per half-period still needs one flop of width.
  localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int BIT_W = $clog2(DR_W + 1);
  localparam int RTI_W = (RTI_CYC > 1) ? $clog2(RTI_CYC) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_W - 1);
  localparam logic [RTI_W-1:0] RTI_LAST = RTI_W'(RTI_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UIR,
    S_CDR,
    S_SDR,
    S_UDR,
    S_RTI
  } state_t;

  state_t          r_state;
  logic [DIV_W-1:0] r_divCnt;
  logic [BIT_W-1:0] r_bitCnt;
  logic [RTI_W-1:0] r_rtiCnt;
  logic [DR_W-1:0] r_sr;
  logic            r_tck;
  logic            r_tdi;
  logic [1:0]      r_irIn;
  logic [1:0]      r_irSample;
  logic            r_uir;
  logic            r_cdr;
  logic            r_sdr;
  logic            r_udr;
  logic            r_rti;
  logic            r_cmdReady;
  logic            r_rspValid;
  logic [DR_W-1:0] r_rspDr;
  logic [1:0]      r_rspIrOut;
`ifdef DNN_VJTAG_DRV_IR_SKIP_EN
  logic            r_uirDone;
`endif

  logic w_divDone;
  logic w_tckRise;
  logic w_periodEnd;
  logic w_accept;

  // The last clk of each half-period decides the tck edge: a rise is where tdo
  // is sampled, a fall closes the tck period and is the only point where the
  // state, the qualifiers and tdi are allowed to move.
  always_comb begin
    w_divDone   = (r_divCnt == DIV_LAST);
    w_tckRise   = (r_state != S_IDLE) && w_divDone && !r_tck;
    w_periodEnd = (r_state != S_IDLE) && w_divDone && r_tck;
    w_accept    = bus.cmd_valid && r_cmdReady;
  end

  // Single sequencer: tck divider, shift register, counters and all registered
  // outputs. Accepting a command starts the first tck period with tck low, so
  // the accept edge doubles as the "tck falls" edge for the first qualifier.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_divCnt   <= '0;
      r_bitCnt   <= '0;
      r_rtiCnt   <= '0;
      r_sr       <= '0;
      r_tck      <= 1'b0;
      r_tdi      <= 1'b0;
      r_irIn     <= 2'b00;
      r_irSample <= 2'b00;
      r_uir      <= 1'b0;
      r_cdr      <= 1'b0;
      r_sdr      <= 1'b0;
      r_udr      <= 1'b0;
      r_rti      <= 1'b0;
      r_cmdReady <= 1'b1;
      r_rspValid <= 1'b0;
      r_rspDr    <= '0;
      r_rspIrOut <= 2'b00;
`ifdef DNN_VJTAG_DRV_IR_SKIP_EN
      r_uirDone  <= 1'b0;
`endif
    end else begin
      r_rspValid <= 1'b0;
      if (r_state == S_IDLE) begin
        r_divCnt <= '0;
        r_tck    <= 1'b0;
        if (w_accept) begin
          r_irIn     <= bus.cmd_ir;
          r_sr       <= bus.cmd_dr;
          r_cmdReady <= 1'b0;
`ifdef DNN_VJTAG_DRV_IR_SKIP_EN
          if (r_uirDone && (bus.cmd_ir == r_irIn)) begin
            r_state <= S_CDR;
            r_cdr   <= 1'b1;
          end else begin
            r_state <= S_UIR;
            r_uir   <= 1'b1;
          end
`else
          r_state <= S_UIR;
          r_uir   <= 1'b1;
`endif
        end
      end else begin
        if (w_divDone) begin
          r_divCnt <= '0;
          r_tck    <= ~r_tck;
        end else begin
          r_divCnt <= r_divCnt + DIV_W'(1);
        end

        // tdo enters at the top so the first captured bit ends up in bit 0.
        if (w_tckRise && (r_state == S_SDR)) begin
          r_sr <= {i_vji_tdo, r_sr[DR_W-1:1]};
        end

        if (w_periodEnd) begin
          case (r_state)
            S_UIR: begin
              r_irSample <= i_vji_ir_out;
              r_uir      <= 1'b0;
              r_cdr      <= 1'b1;
              r_state    <= S_CDR;
`ifdef DNN_VJTAG_DRV_IR_SKIP_EN
              r_uirDone  <= 1'b1;
`endif
            end
            S_CDR: begin
              r_cdr   <= 1'b0;
              r_sdr   <= 1'b1;
              r_tdi   <= r_sr[0];
              r_state <= S_SDR;
            end
            S_SDR: begin
              // r_sr already shifted on this period's rise, so bit 0 is the
              // next bit to present on tdi.
              if (r_bitCnt == BIT_LAST) begin
                r_bitCnt <= '0;
                r_sdr    <= 1'b0;
                r_udr    <= 1'b1;
                r_tdi    <= 1'b0;
                r_state  <= S_UDR;
              end else begin
                r_bitCnt <= r_bitCnt + BIT_W'(1);
                r_tdi    <= r_sr[0];
              end
            end
            S_UDR: begin
              r_udr    <= 1'b0;
              r_rti    <= 1'b1;
              r_rtiCnt <= '0;
              r_state  <= S_RTI;
            end
            S_RTI: begin
              if (r_rtiCnt == RTI_LAST) begin
                r_rtiCnt   <= '0;
                r_rti      <= 1'b0;
                r_rspValid <= 1'b1;
                r_rspDr    <= r_sr;
                r_rspIrOut <= r_irSample;
                r_cmdReady <= 1'b1;
                r_state    <= S_IDLE;
              end else begin
                r_rtiCnt <= r_rtiCnt + RTI_W'(1);
              end
            end
            default: begin
              r_uir   <= 1'b0;
              r_cdr   <= 1'b0;
              r_sdr   <= 1'b0;
              r_udr   <= 1'b0;
              r_rti   <= 1'b0;
              r_tdi   <= 1'b0;
              r_state <= S_IDLE;
            end
          endcase
        end
      end
    end
  end

  assign bus.cmd_ready  = r_cmdReady;
  assign bus.busy       = ~r_cmdReady;
  assign bus.rsp_valid  = r_rspValid;
  assign bus.rsp_dr     = r_rspDr;
  assign bus.rsp_ir_out = r_rspIrOut;

  assign o_vji_tck   = r_tck;
  assign o_vji_tdi   = r_tdi;
  assign o_vji_ir_in = r_irIn;
  assign o_vji_uir   = r_uir;
  assign o_vji_cdr   = r_cdr;
  assign o_vji_sdr   = r_sdr;
  assign o_vji_udr   = r_udr;
  assign o_vji_rti   = r_rti;

endmodule

// File: tb/tb_blk_332794.sv
// ---------------------------------------------------------------------------
// tb_blk_332794
// Directed bench for the virtual-JTAG debug driver: reset state, loopback
// shifting, tdo tied high, IR status capture, back-to-back commands, dropped
// requests while busy and the repeated-IR case (DNN_VJTAG_DRV_IR_SKIP_EN).
// ---------------------------------------------------------------------------
module tb_blk_332794;

  localparam logic [37:0] DIN_A  = 38'h2A_5555_AAAA;
  localparam logic [37:0] LOOP_A = 38'h14_AAAB_5554;
  localparam logic [37:0] DIN_B  = 38'h0F_0F0F_0F0F;
  localparam logic [37:0] LOOP_B = 38'h1E_1E1E_1E1E;

  localparam logic [4:0] Q_UIR = 5'b10000;
  localparam logic [4:0] Q_CDR = 5'b01000;
  localparam logic [4:0] Q_SDR = 5'b00100;
  localparam logic [4:0] Q_UDR = 5'b00010;
  localparam logic [4:0] Q_RTI = 5'b00001;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       vjiTck, vjiTdi, vjiTdo;
  logic [1:0] vjiIrIn;
  logic [1:0] vjiIrOut = 2'b00;
  logic       vjiUir, vjiCdr, vjiSdr, vjiUdr, vjiRti;
  logic       lbReg = 1'b0;
  logic       tieOne = 1'b0;

  int nChecks = 0;
  int nFails  = 0;

  int cyc = 0;
  int acceptCount = 0;
  int rspCount = 0;
  int acceptCyc[$];
  int rspCyc[$];
  logic [37:0] lastRspDr = '0;
  logic [1:0]  lastRspIr = 2'b00;
  logic [4:0]  qSeq[$];
  logic        tdiSeq[$];

  blk_332794_if #(.DR_W(38)) bus ();

  always #5 clk = ~clk;

  blk_332794 dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .i_vji_tdo    (vjiTdo),
    .i_vji_ir_out (vjiIrOut),
    .o_vji_tck    (vjiTck),
    .o_vji_tdi    (vjiTdi),
    .o_vji_ir_in  (vjiIrIn),
    .o_vji_uir    (vjiUir),
    .o_vji_cdr    (vjiCdr),
    .o_vji_sdr    (vjiSdr),
    .o_vji_udr    (vjiUdr),
    .o_vji_rti    (vjiRti)
  );

  // Loopback slave: tdo replays the tdi seen at the previous tck rise.
  always @(posedge vjiTck) lbReg <= vjiTdi;
  assign vjiTdo = tieOne ? 1'b1 : lbReg;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", tag, observed, expected);
    end
  endtask

  // Handshake monitor, sampled with pre-edge values at each clk rise.
  always @(posedge clk) begin
    cyc++;
    if (bus.cmd_valid && bus.cmd_ready) begin
      acceptCount++;
      acceptCyc.push_back(cyc);
    end
    if (bus.rsp_valid) begin
      rspCount++;
      rspCyc.push_back(cyc);
      lastRspDr = bus.rsp_dr;
      lastRspIr = bus.rsp_ir_out;
    end
  end

  // Qualifier trace: one entry per tck rise, plus tdi during shift.
  always @(posedge vjiTck) begin
    qSeq.push_back({vjiUir, vjiCdr, vjiSdr, vjiUdr, vjiRti});
    if (vjiSdr) tdiSeq.push_back(vjiTdi);
    checkOutput("onehot", 64'($countones({vjiUir, vjiCdr, vjiSdr, vjiUdr, vjiRti})), 64'd1);
  end

  function automatic logic [4:0] expQ(input int idx, input int base);
    int j;
    j = idx + base;
    if (j == 0) return Q_UIR;
    if (j == 1) return Q_CDR;
    if (j < 40) return Q_SDR;
    if (j == 40) return Q_UDR;
    return Q_RTI;
  endfunction

  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Present one command and drop cmd_valid once it has been accepted.
  task automatic applyStimulus(input logic [1:0] ir, input logic [37:0] dr);
    int a0;
    a0 = acceptCount;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_ir    = ir;
    bus.cmd_dr    = dr;
    for (int i = 0; i < 50 && acceptCount == a0; i++) @(negedge clk);
    bus.cmd_valid = 1'b0;
    checkOutput("accept_seen", 64'(acceptCount - a0), 64'd1);
  endtask

  task automatic waitRsp(input int r0);
    for (int i = 0; i < 400 && rspCount == r0; i++) @(negedge clk);
    checkOutput("rsp_seen", 64'(rspCount != r0), 64'd1);
  endtask

  function automatic int lastLatency();
    return rspCyc[rspCyc.size()-1] - acceptCyc[acceptCyc.size()-1] - 1;
  endfunction

  initial begin
    int r0;
    int a0;
    int ones;
    bus.cmd_valid = 1'b0;
    bus.cmd_ir    = 2'b00;
    bus.cmd_dr    = '0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_tck", 64'(vjiTck), 64'd0);
    checkOutput("rst_tdi", 64'(vjiTdi), 64'd0);
    checkOutput("rst_irin", 64'(vjiIrIn), 64'd0);
    checkOutput("rst_qual", 64'({vjiUir, vjiCdr, vjiSdr, vjiUdr, vjiRti}), 64'd0);
    checkOutput("rst_ready", 64'(bus.cmd_ready), 64'd1);
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_rspv", 64'(bus.rsp_valid), 64'd0);
    checkOutput("rst_rspdr", 64'(bus.rsp_dr), 64'd0);
    checkOutput("rst_rspir", 64'(bus.rsp_ir_out), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Loopback shift of DIN_A
    qSeq.delete();
    tdiSeq.delete();
    r0 = rspCount;
    applyStimulus(2'b01, DIN_A);
    checkOutput("busy_run", 64'(bus.busy), 64'd1);
    waitRsp(r0);
    repeat (5) @(negedge clk);
    checkOutput("lb_rspcount", 64'(rspCount - r0), 64'd1);
    checkOutput("lb_latency", 64'(lastLatency()), 64'd172);
    checkOutput("lb_rspdr", 64'(lastRspDr), 64'(LOOP_A));
    checkOutput("lb_rspdr_held", 64'(bus.rsp_dr), 64'(LOOP_A));
    checkOutput("lb_rspir", 64'(lastRspIr), 64'd0);
    checkOutput("lb_qlen", 64'(qSeq.size()), 64'd43);
    for (int i = 0; i < qSeq.size() && i < 43; i++)
      checkOutput($sformatf("lb_q%0d", i), 64'(qSeq[i]), 64'(expQ(i, 0)));
    checkOutput("lb_tdilen", 64'(tdiSeq.size()), 64'd38);
    for (int i = 0; i < tdiSeq.size() && i < 38; i++)
      checkOutput($sformatf("lb_tdi%0d", i), 64'(tdiSeq[i]), 64'(DIN_A[i]));
    checkOutput("lb_ready", 64'(bus.cmd_ready), 64'd1);
    checkOutput("lb_idle_qual", 64'({vjiUir, vjiCdr, vjiSdr, vjiUdr, vjiRti}), 64'd0);

    // tdo tied high, zero DR
    doReset();
    tieOne = 1'b1;
    tdiSeq.delete();
    r0 = rspCount;
    applyStimulus(2'b01, 38'h0);
    waitRsp(r0);
    tieOne = 1'b0;
    checkOutput("one_rspdr", 64'(lastRspDr), 64'h3F_FFFF_FFFF);
    checkOutput("one_tdilen", 64'(tdiSeq.size()), 64'd38);
    ones = 0;
    foreach (tdiSeq[i]) if (tdiSeq[i] !== 1'b0) ones++;
    checkOutput("one_tdi_zero", 64'(ones), 64'd0);

    // IR status capture
    doReset();
    vjiIrOut = 2'b10;
    r0 = rspCount;
    applyStimulus(2'b01, 38'h1);
    waitRsp(r0);
    vjiIrOut = 2'b00;
    checkOutput("ir_rspir", 64'(lastRspIr), 64'd2);
    checkOutput("ir_rspir_held", 64'(bus.rsp_ir_out), 64'd2);
    checkOutput("ir_irin_idle", 64'(vjiIrIn), 64'd1);
    repeat (20) @(negedge clk);
    checkOutput("ir_irin_hold", 64'(vjiIrIn), 64'd1);

    // Reset in the middle of the shift
    doReset();
    applyStimulus(2'b01, DIN_A);
    repeat (30) @(negedge clk);
    checkOutput("mid_in_sdr", 64'(vjiSdr), 64'd1);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_qual", 64'({vjiUir, vjiCdr, vjiSdr, vjiUdr, vjiRti}), 64'd0);
    checkOutput("mid_tck_tdi", 64'({vjiTck, vjiTdi}), 64'd0);
    checkOutput("mid_irin", 64'(vjiIrIn), 64'd0);
    checkOutput("mid_ready", 64'(bus.cmd_ready), 64'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    r0 = rspCount;
    repeat (250) @(negedge clk);
    checkOutput("mid_no_rsp", 64'(rspCount - r0), 64'd0);
    checkOutput("mid_rspdr", 64'(bus.rsp_dr), 64'd0);

    // Back-to-back with cmd_valid held high
    doReset();
    r0 = rspCount;
    a0 = acceptCount;
    bus.cmd_valid = 1'b1;
    bus.cmd_ir    = 2'b01;
    bus.cmd_dr    = DIN_A;
    for (int i = 0; i < 50 && acceptCount == a0; i++) @(negedge clk);
    bus.cmd_dr = DIN_B;
    for (int i = 0; i < 400 && acceptCount < a0 + 2; i++) @(negedge clk);
    bus.cmd_valid = 1'b0;
    checkOutput("b2b_accepts", 64'(acceptCount - a0), 64'd2);
    checkOutput("b2b_rsp_first", 64'(rspCount - r0), 64'd1);
    if (acceptCount - a0 == 2 && rspCount - r0 >= 1)
      checkOutput("b2b_gap", 64'(acceptCyc[a0+1] - rspCyc[r0]), 64'd0);
    checkOutput("b2b_rspdr1", 64'(lastRspDr), 64'(LOOP_A));
    waitRsp(r0 + 1);
    checkOutput("b2b_rspdr2", 64'(lastRspDr), 64'(LOOP_B));

    // Request pulsed while busy is dropped
    r0 = rspCount;
    a0 = acceptCount;
    applyStimulus(2'b01, DIN_B);
    repeat (20) @(negedge clk);
    bus.cmd_valid = 1'b1;
    repeat (5) @(negedge clk);
    bus.cmd_valid = 1'b0;
    waitRsp(r0);
    repeat (200) @(negedge clk);
    checkOutput("drop_accepts", 64'(acceptCount - a0), 64'd1);
    checkOutput("drop_rsps", 64'(rspCount - r0), 64'd1);

    // Repeated IR
    doReset();
    r0 = rspCount;
    applyStimulus(2'b11, DIN_A);
    waitRsp(r0);
    checkOutput("rep_lat1", 64'(lastLatency()), 64'd172);
    qSeq.delete();
    r0 = rspCount;
    applyStimulus(2'b11, DIN_B);
    waitRsp(r0);
    ones = 0;
    foreach (qSeq[i]) if (qSeq[i] === Q_UIR) ones++;
`ifdef DNN_VJTAG_DRV_IR_SKIP_EN
    checkOutput("rep_uir_count", 64'(ones), 64'd0);
    checkOutput("rep_qlen", 64'(qSeq.size()), 64'd42);
    checkOutput("rep_lat2", 64'(lastLatency()), 64'd168);
    for (int i = 0; i < qSeq.size() && i < 42; i++)
      checkOutput($sformatf("rep_q%0d", i), 64'(qSeq[i]), 64'(expQ(i, 1)));
`else
    checkOutput("rep_uir_count", 64'(ones), 64'd1);
    checkOutput("rep_qlen", 64'(qSeq.size()), 64'd43);
    checkOutput("rep_lat2", 64'(lastLatency()), 64'd172);
`endif
    checkOutput("rep_rspdr", 64'(lastRspDr), 64'(LOOP_B));
    checkOutput("rep_irin", 64'(vjiIrIn), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
